// File: rtl/trdb_resync_timer.sv
// rtl/trdb_resync_timer.sv - resync scheduler counting cycles or packets toward a sticky sync request
module trdb_resync_timer #(
  parameter int unsigned CNT_W    = 16,
  parameter logic        RST_MODE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trace_enabled_i,
  input  logic             mode_i,
  input  logic             mode_we_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic             packet_emitted_i,
  input  logic             resync_ack_i,
  input  logic             force_resync_i,
  output logic             resync_req_o,
  output logic [CNT_W-1:0] count_o,
  output logic             mode_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             mode_q, mode_d;
  logic             ev, mode_change;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= RST_MODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_we_i ? mode_i : mode_q;
    mode_change = mode_we_i && (mode_i != mode_q);
    ev          = mode_q ? packet_emitted_i : 1'b1;
    cnt_inc     = cnt_q + CntOne;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trace_enabled_i) state_d = COUNT;
      end
      COUNT: begin
        if (!trace_enabled_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (resync_ack_i) begin
          cnt_d = '0;
        end else if (force_resync_i) begin
          state_d = PENDING;
        end else if (ev && !mode_change) begin
          // Wrapping increment; a lowered threshold only matches after wrap-around.
          cnt_d = cnt_inc;
          if ((threshold_i != '0) && (cnt_inc == threshold_i)) state_d = PENDING;
        end
      end
      PENDING: begin
        if (!trace_enabled_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (resync_ack_i) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A real mode switch restarts the period; a pending request survives it.
    if (mode_change) cnt_d = '0;
  end

  assign resync_req_o = (state_q == PENDING);
  assign count_o      = cnt_q;
  assign mode_o       = mode_q;

endmodule

// File: tb/tb_trdb_resync_timer.sv
// tb/tb_trdb_resync_timer.sv - directed self-checking bench for trdb_resync_timer
module tb_trdb_resync_timer;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, mode, mode_we, pkt, ack, force_r;
  logic [CNT_W-1:0] thr;
  logic             req, mode_out;
  logic [CNT_W-1:0] count;

  int ntests = 0;
  int nfail  = 0;
  logic saw_req;

  trdb_resync_timer #(.CNT_W(CNT_W), .RST_MODE(1'b0)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .trace_enabled_i (en),
    .mode_i          (mode),
    .mode_we_i       (mode_we),
    .threshold_i     (thr),
    .packet_emitted_i(pkt),
    .resync_ack_i    (ack),
    .force_resync_i  (force_r),
    .resync_req_o    (req),
    .count_o         (count),
    .mode_o          (mode_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; mode = 0; mode_we = 0; pkt = 0; ack = 0; force_r = 0; thr = '0;
    step(); step();
    chk("rst_req", 32'(req), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_mode", 32'(mode_out), 0);
    rst_n = 1'b1;

    // Cycle mode, threshold 4
    thr = 4'd4; en = 1;
    step();
    chk("t1_enable_count", 32'(count), 0);
    step(); chk("t1_c1", 32'(count), 1);
    step(); chk("t1_c2", 32'(count), 2);
    step(); chk("t1_c3", 32'(count), 3);
    chk("t1_noreq", 32'(req), 0);
    step(); chk("t1_c4", 32'(count), 4);
    chk("t1_req", 32'(req), 1);
    step(); step();
    chk("t1_sat", 32'(count), 4);
    chk("t1_hold", 32'(req), 1);
    ack = 1; step(); ack = 0;
    chk("t1_ack_req", 32'(req), 0);
    chk("t1_ack_count", 32'(count), 0);
    step(); chk("t1_restart", 32'(count), 1);

    // Packet mode, threshold 3, packets on cycles 2, 7, 9
    en = 0; step();
    mode = 1; mode_we = 1; step(); mode_we = 0;
    chk("t2_mode", 32'(mode_out), 1);
    thr = 4'd3; en = 1;
    step();
    for (int c = 2; c <= 9; c++) begin
      pkt = (c == 2 || c == 7 || c == 9);
      step();
      if (c == 8) begin
        chk("t2_c8_count", 32'(count), 2);
        chk("t2_c8_noreq", 32'(req), 0);
      end
    end
    pkt = 0;
    chk("t2_req", 32'(req), 1);
    chk("t2_count", 32'(count), 3);
    ack = 1; pkt = 1; step(); ack = 0; pkt = 0;
    chk("t2_ack_req", 32'(req), 0);
    chk("t2_ack_pkt", 32'(count), 0);

    // Threshold 0, cycle mode, wrap
    en = 0; mode = 0; mode_we = 1; step(); mode_we = 0;
    thr = '0; en = 1; step();
    saw_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req) saw_req = 1'b1;
    end
    chk("t3_never_req", 32'(saw_req), 0);
    chk("t3_wrap", 32'(count), 100 % 16);
    force_r = 1; step(); force_r = 0;
    chk("t3_force_req", 32'(req), 1);
    step(); step();
    chk("t3_force_hold", 32'(req), 1);
    ack = 1; step(); ack = 0;
    chk("t3_ack_req", 32'(req), 0);
    chk("t3_ack_count", 32'(count), 0);

    // Disable mid-count and disable with simultaneous ack
    thr = 4'd5;
    step(); step();
    chk("t4_c2", 32'(count), 2);
    en = 0; step(); en = 1;
    chk("t4_dis_count", 32'(count), 0);
    step();
    chk("t4_reen_count", 32'(count), 0);
    chk("t4_reen_req", 32'(req), 0);
    force_r = 1; step(); force_r = 0;
    chk("t4_pending", 32'(req), 1);
    en = 0; ack = 1; step(); ack = 0;
    chk("t4_disack_req", 32'(req), 0);
    chk("t4_disack_count", 32'(count), 0);
    en = 1; step(); step();
    chk("t4_counting", 32'(count), 1);
    chk("t4_counting_req", 32'(req), 0);

    // Mode writes
    step(); step();
    chk("t5_c3", 32'(count), 3);
    mode = 1; mode_we = 1; step(); mode_we = 0;
    chk("t5_switch_count", 32'(count), 0);
    chk("t5_switch_mode", 32'(mode_out), 1);
    pkt = 1; step(); step(); pkt = 0;
    chk("t5_pkt_count", 32'(count), 2);
    mode_we = 1; step(); mode_we = 0;
    chk("t5_same_count", 32'(count), 2);

    // Asynchronous reset while pending
    force_r = 1; step(); force_r = 0;
    chk("t6_pending", 32'(req), 1);
    #2; rst_n = 1'b0; #1;
    chk("t6_async_req", 32'(req), 0);
    chk("t6_async_count", 32'(count), 0);
    chk("t6_async_mode", 32'(mode_out), 0);
    step();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/trdb_resync_timer.md
Name: trdb_resync_timer

Overview:
Parametrised resync scheduler for the trace encoder. It counts either clock cycles or emitted packets while tracing is enabled, and raises a sticky resync request when a runtime-programmable threshold is reached. The request holds until the packet emitter acknowledges that a sync packet was sent. It sits between the encoder control registers and the packet emitter's packet-type selection.

Parameters:
CNT_W, 16, width of the event counter and of the threshold input (legal range 2..32)
RST_MODE, 1'b0, counting mode used when no mode write has occurred (0 = cycle, 1 = packet)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
trace_enabled_i  input  1  tracing active; counting only while high
mode_i  input  1  counting mode: 0 = cycle mode, 1 = packet mode
mode_we_i  input  1  one-cycle strobe; mode_i is sampled into the internal mode register
threshold_i  input  CNT_W  resync period in counted events; 0 disables request generation
packet_emitted_i  input  1  one-cycle pulse per packet emitted
resync_ack_i  input  1  emitter sent a sync packet this cycle
force_resync_i  input  1  software or trigger request for an immediate resync
resync_req_o  output  1  sticky resync request to the emitter
count_o  output  CNT_W  current counter value, for debug and CSR readback
mode_o  output  1  current internal mode register

Behaviour:
- Reset values: resync_req_o = 0, count_o = 0, mode_o = RST_MODE, state = IDLE. Reset is asynchronous and may arrive at any time, including while PENDING; the request drops immediately.
- Counted event ("ev") per cycle: in cycle mode, ev = 1; in packet mode, ev = packet_emitted_i.
- State machine with three states: IDLE, COUNT, PENDING.
  - IDLE: counter is held at 0 and resync_req_o = 0. Moves to COUNT on the first cycle trace_enabled_i = 1. No event is counted in that cycle.
  - COUNT: if ev is true, the counter increments by 1 on the next edge.
    - If the incremented value equals threshold_i and threshold_i != 0, the next state is PENDING and resync_req_o = 1 from the next cycle.
    - Request latency is therefore 1 cycle after the threshold-reaching event.
  - PENDING: resync_req_o = 1. The counter saturates at its value and further ev is ignored.
    - On resync_ack_i = 1: counter becomes 0, request becomes 0, next state is COUNT. The ack cycle's own ev is not counted, because the sync packet itself does not count toward the next period.
- force_resync_i in COUNT moves to PENDING on the next edge regardless of count or threshold, including threshold 0. In PENDING it has no effect. In IDLE it is ignored.
- trace_enabled_i = 0 in any state moves to IDLE on the next edge: counter cleared, request dropped, and a pending request is discarded. Disable has priority over ack, force and ev.
- Priority within COUNT/PENDING: disable > ack > force > threshold match > increment.
- mode_we_i = 1: the mode register updates on the next edge. If the new value differs from the current mode, the counter clears to 0. A PENDING request is kept.
- Threshold rules:
  - threshold_i is sampled every cycle and compared against the incremented value.
  - If threshold_i is lowered below the current count, the next event does not match. The counter keeps counting until it wraps through the new threshold value.
  - The counter wraps from 2^CNT_W-1 to 0 with no flag.
  - threshold_i = 0 means no automatic requests; only force produces a request.
- ack in COUNT or IDLE clears the counter in COUNT and is otherwise ignored; no request is generated.
- count_o and resync_req_o are registered outputs with no combinational paths from inputs.

Test Plan:
1. Cycle mode, threshold = 4, enable held high: count_o steps 1,2,3,4 on cycles 2..5 after enable, and resync_req_o rises on the cycle count_o = 4. Ack 3 cycles later: req falls and count_o = 0 on the next cycle.
2. Packet mode, threshold = 3, packets on cycles 2, 7, 9: req rises the cycle after the cycle-9 packet. A packet coincident with the ack is not counted (count_o = 0 afterwards).
3. Threshold = 0 in cycle mode for 100 cycles: req never rises and count_o wraps at CNT_W = 4. Then force pulse: req rises the next cycle, held until ack.
4. Count = 2 of threshold 5, disable for 1 cycle, then re-enable: count_o = 0 and req = 0. After a PENDING request, disable plus simultaneous ack: IDLE, req = 0.
5. Mode write cycle→packet at count 3: count_o = 0 next cycle and mode_o = 1. Mode write with the same value: count unaffected.
6. Assert rst_ni low mid-PENDING, asynchronous to clk_i: req and count drop immediately, mode_o returns to RST_MODE.
